timebase_gen: RTL and testbench
===============================

# timebase_gen

Parametrised timebase generator for the alarm-clock datapath. It replaces the fixed 100 Hz toggle divider with one block that produces three things from the system clock:
- single-cycle clock-enable ticks at 100 Hz, 10 Hz and 1 Hz;
- a legacy 50 %-duty 100 Hz square wave;
- a 1 Hz 50 %-duty blink signal for the display.

It also adds run/pause, a synchronous clear, and a fast mode for time setting. All downstream counters (time-of-day, alarm, display mux) consume its ticks as enables on `clk`.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency in Hz.
- `TICK_HZ`, 100, base tick rate in Hz.
- Derived: DIV = CLK_HZ/TICK_HZ; CNT_W = clog2(DIV).
- Elaboration error unless CLK_HZ % (2*TICK_HZ) == 0 and DIV >= 4.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = timebase advances; 0 = all counters hold.
- `clear`  in  1  synchronous restart of all counters; same effect as `rst`.
- `fast`  in  1  1 = `tick_1hz` fires on every base tick.
- `tick_100hz`  out  1  one-cycle pulse, period DIV.
- `tick_10hz`  out  1  one-cycle pulse, period 10*DIV.
- `tick_1hz`  out  1  one-cycle pulse, period 100*DIV (DIV when `fast`).
- `clk_100hz`  out  1  square wave, period DIV, 50 % duty.
- `blink`  out  1  square wave, period 100*DIV, high for the first half.

## Operation
- Registers:
  - `base_cnt` [CNT_W], counts 0..DIV-1;
  - `c10` [4], counts 0..9;
  - `c1` [4], counts 0..9;
  - all outputs are registered.
- Strobe: s = run & (base_cnt == DIV-1).
- Each edge with `run` = 1: `base_cnt` <= s ? 0 : base_cnt+1.
- On an edge with s: `c10` <= (c10 == 9) ? 0 : c10+1.
- On an edge with s and `c10` == 9: `c1` <= (c1 == 9) ? 0 : c1+1.
- Tick registers, updated every edge:
  - `tick_100hz` <= s;
  - `tick_10hz` <= s & (c10 == 9);
  - `tick_1hz` <= fast ? s : s & (c10 == 9) & (c1 == 9).
- `clk_100hz` toggles on edges where `run` & (base_cnt == DIV/2-1 | base_cnt == DIV-1).
- `blink` <= (c1_next <= 4), where c1_next is the value `c1` takes on the same edge. `blink` is therefore aligned with `c1`, with no extra lag.
- `run` = 0: all counters, `clk_100hz` and `blink` hold; all tick outputs are 0 from the next edge. Resuming continues from the held count.
- `fast` changes only `tick_1hz`. `c10` and `c1` keep counting normally. Toggling `fast` mid-period takes effect on the next strobe.
- `rst` or `clear`: counters 0, ticks 0, `clk_100hz` 0, `blink` 1. `rst` and `clear` take priority over `run`.

## Timing
- Reset values: `tick_100hz`, `tick_10hz`, `tick_1hz` = 0; `clk_100hz` = 0; `blink` = 1.
- After `rst`/`clear` deasserts with `run` = 1:
  - first `tick_100hz` is high in the cycle after edge DIV, i.e. after exactly DIV edges;
  - first `tick_10hz` after 10*DIV edges;
  - first `tick_1hz` after 100*DIV edges.
- Coincidence: `tick_1hz` implies `tick_10hz` implies `tick_100hz` in the same cycle.
- Each tick is high for exactly 1 cycle and never high in two consecutive cycles (DIV >= 4).
- `clk_100hz`:
  - first rises after DIV/2 edges;
  - high for DIV/2 cycles, low for DIV/2 cycles.
- `blink` falls on the edge where `c1` goes 4→5 and rises on the edge where `c1` goes 9→0. The rise is coincident with `tick_1hz` in normal mode.
- `clear` asserted on the same edge as a strobe: `clear` wins, and no tick is emitted in the following cycle.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset release with `run`=1:
  - `tick_100hz` pulses 1 cycle at edges 10, 20, 30…;
  - `tick_10hz` at edge 100;
  - `tick_1hz` at edge 1000;
  - `clk_100hz` rises at edge 5 and falls at edge 10.
- Blink:
  - `blink` = 1 through edge 499, falls at edge 500, rises at edge 1000 together with `tick_1hz`;
  - `blink` and all outputs are at reset values during `rst`.
- Pause: drop `run` at edge 37 for 50 cycles.
  - No ticks during the pause;
  - `clk_100hz` and `blink` frozen;
  - next `tick_100hz` arrives 3 edges after `run` returns (`base_cnt` resumes from 7).
- Fast: `fast`=1 from reset.
  - `tick_1hz` pulses at edges 10, 20, 30…;
  - `tick_10hz` still pulses only at edges 100, 200…
- Clear at a strobe: assert `clear` on edge 10.
  - No tick in the following cycle;
  - next `tick_100hz` arrives 10 edges after `clear` deasserts;
  - `blink` = 1, `clk_100hz` = 0.
- Long run for 10 000 edges:
  - exactly 1000/100/10 pulses of the 100/10/1 Hz ticks;
  - the tick coincidence invariant is checked every cycle.

Source files
------------

// File: rtl/timebase_gen.sv
// ---------------------------------------------------------------------------
// timebase_gen
//
// Timebase for the alarm-clock datapath. From the system clock it derives
// single-cycle clock-enable ticks at TICK_HZ, TICK_HZ/10 and TICK_HZ/100. It
// also produces a 50 %-duty square wave at TICK_HZ (the legacy divided clock)
// and a 50 %-duty blink at TICK_HZ/100. Downstream logic uses the ticks as
// enables on clk; it does not use them as clocks.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz
//   TICK_HZ     base tick rate in Hz (DIV = CLK_HZ / TICK_HZ clocks per tick)
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous, active-high reset
//   run         1 = timebase advances, 0 = counters, clk_100hz and blink hold
//   clear       synchronous restart, same effect as rst
//   fast        1 = tick_1hz fires on every base tick (time-setting mode)
//   tick_100hz  one-cycle pulse every DIV clocks
//   tick_10hz   one-cycle pulse every 10*DIV clocks
//   tick_1hz    one-cycle pulse every 100*DIV clocks (every DIV when fast)
//   clk_100hz   square wave, period DIV, 50 % duty
//   blink       square wave, period 100*DIV, high for the first half
// ---------------------------------------------------------------------------
module timebase_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    input  logic fast,
    output logic tick_100hz,
    output logic tick_10hz,
    output logic tick_1hz,
    output logic clk_100hz,
    output logic blink
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    // An odd DIV would make the square wave asymmetric. A DIV below 4 would
    // let a tick be high in back-to-back cycles.
    generate
        if (((CLK_HZ % (2 * TICK_HZ)) != 0) || (DIV < 4)) begin : g_param_check
            $error("timebase_gen: CLK_HZ must be a multiple of 2*TICK_HZ and DIV >= 4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] base_cnt_q, base_cnt_d;
    logic [3:0]       c10_q, c10_d;
    logic [3:0]       c1_q, c1_d;
    logic             tick_100hz_q, tick_100hz_d;
    logic             tick_10hz_q, tick_10hz_d;
    logic             tick_1hz_q, tick_1hz_d;
    logic             clk_100hz_q, clk_100hz_d;
    logic             blink_q, blink_d;

    logic strobe;
    logic c10_wrap;
    logic c1_wrap;

    always_comb begin
        strobe   = run && (base_cnt_q == CNT_LAST);
        c10_wrap = (c10_q == 4'd9);
        c1_wrap  = (c1_q == 4'd9);

        base_cnt_d = base_cnt_q;
        if (run) begin
            base_cnt_d = strobe ? '0 : base_cnt_q + CNT_ONE;
        end

        c10_d = c10_q;
        if (strobe) begin
            c10_d = c10_wrap ? 4'd0 : c10_q + 4'd1;
        end

        c1_d = c1_q;
        if (strobe && c10_wrap) begin
            c1_d = c1_wrap ? 4'd0 : c1_q + 4'd1;
        end

        tick_100hz_d = strobe;
        tick_10hz_d  = strobe && c10_wrap;
        // fast only re-times tick_1hz; c10/c1 keep their normal cadence.
        tick_1hz_d   = fast ? strobe : (strobe && c10_wrap && c1_wrap);

        // Toggle at mid-period and at wrap, so the wave is high for the
        // second half of every base period.
        clk_100hz_d = clk_100hz_q ^ (run && ((base_cnt_q == CNT_HALF) ||
                                             (base_cnt_q == CNT_LAST)));

        // Computed from the next c1 value so that blink changes on the same
        // edge as c1, with no extra cycle of lag.
        blink_d = (c1_d <= 4'd4);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            base_cnt_q   <= '0;
            c10_q        <= 4'd0;
            c1_q         <= 4'd0;
            tick_100hz_q <= 1'b0;
            tick_10hz_q  <= 1'b0;
            tick_1hz_q   <= 1'b0;
            clk_100hz_q  <= 1'b0;
            blink_q      <= 1'b1;
        end else begin
            base_cnt_q   <= base_cnt_d;
            c10_q        <= c10_d;
            c1_q         <= c1_d;
            tick_100hz_q <= tick_100hz_d;
            tick_10hz_q  <= tick_10hz_d;
            tick_1hz_q   <= tick_1hz_d;
            clk_100hz_q  <= clk_100hz_d;
            blink_q      <= blink_d;
        end
    end

    assign tick_100hz = tick_100hz_q;
    assign tick_10hz  = tick_10hz_q;
    assign tick_1hz   = tick_1hz_q;
    assign clk_100hz  = clk_100hz_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_timebase_gen.sv
// ---------------------------------------------------------------------------
// tb_timebase_gen
//
// Directed bench for timebase_gen with CLK_HZ=1000 and TICK_HZ=100, which
// gives DIV=10. "Edge n" means the n-th rising edge after rst or clear is
// released. Outputs are sampled 1 time unit after each rising edge. Inputs
// are changed at that same point.
// ---------------------------------------------------------------------------
module tb_timebase_gen;

    logic clk = 1'b0;
    logic rst, run, clear, fast;
    logic tick_100hz, tick_10hz, tick_1hz, clk_100hz, blink;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    timebase_gen #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .clear      (clear),
        .fast       (fast),
        .tick_100hz (tick_100hz),
        .tick_10hz  (tick_10hz),
        .tick_1hz   (tick_1hz),
        .clk_100hz  (clk_100hz),
        .blink      (blink)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold rst for three edges and check the reset values. Then release rst,
    // so that the next edge is edge 1.
    task automatic do_reset(input logic run_v, input logic fast_v, input bit chk);
        rst   = 1'b1;
        clear = 1'b0;
        run   = run_v;
        fast  = fast_v;
        repeat (3) step();
        if (chk) begin
            check_eq("rst_t100",  {31'd0, tick_100hz}, 32'd0);
            check_eq("rst_t10",   {31'd0, tick_10hz},  32'd0);
            check_eq("rst_t1",    {31'd0, tick_1hz},   32'd0);
            check_eq("rst_clk",   {31'd0, clk_100hz},  32'd0);
            check_eq("rst_blink", {31'd0, blink},      32'd1);
        end
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic scen_normal();
        logic [31:0] e;
        do_reset(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) exp_q.push_back(32'(k * 100));
        for (int i = 1; i <= 1000; i++) begin
            step();
            e = 32'(i);
            check_eq($sformatf("n_t100@%0d", i),  {31'd0, tick_100hz}, {31'd0, (e % 10) == 0});
            check_eq($sformatf("n_t10@%0d", i),   {31'd0, tick_10hz},  {31'd0, (e % 100) == 0});
            check_eq($sformatf("n_t1@%0d", i),    {31'd0, tick_1hz},   {31'd0, (e % 1000) == 0});
            check_eq($sformatf("n_clk@%0d", i),   {31'd0, clk_100hz},  {31'd0, (e % 10) >= 5});
            check_eq($sformatf("n_blink@%0d", i), {31'd0, blink},      {31'd0, (e % 1000) < 500});
            if (tick_10hz) begin
                if (exp_q.size() == 0) check_eq("sb_t10_extra", e, 32'd0);
                else check_eq("sb_t10_edge", e, exp_q.pop_front());
            end
        end
        check_eq("sb_t10_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic scen_pause();
        do_reset(1'b1, 1'b0, 1'b0);
        repeat (37) step();
        // base_cnt is 7 after edge 37, so clk_100hz is high and blink is high.
        check_eq("p_clk_pre",   {31'd0, clk_100hz}, 32'd1);
        check_eq("p_blink_pre", {31'd0, blink},     32'd1);
        run = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check_eq($sformatf("p_ticks@%0d", i), {29'd0, tick_100hz, tick_10hz, tick_1hz}, 32'd0);
            check_eq($sformatf("p_clk@%0d", i),   {31'd0, clk_100hz}, 32'd1);
            check_eq($sformatf("p_blink@%0d", i), {31'd0, blink},     32'd1);
        end
        run = 1'b1;
        step();
        check_eq("p_res1_t100", {31'd0, tick_100hz}, 32'd0);
        step();
        check_eq("p_res2_t100", {31'd0, tick_100hz}, 32'd0);
        step();
        check_eq("p_res3_t100", {31'd0, tick_100hz}, 32'd1);
        check_eq("p_res3_clk",  {31'd0, clk_100hz},  32'd0);
        step();
        check_eq("p_res4_t100", {31'd0, tick_100hz}, 32'd0);
    endtask

    task automatic scen_fast();
        logic [31:0] e;
        do_reset(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            step();
            e = 32'(i);
            check_eq($sformatf("f_t1@%0d", i),  {31'd0, tick_1hz},  {31'd0, (e % 10) == 0});
            check_eq($sformatf("f_t10@%0d", i), {31'd0, tick_10hz}, {31'd0, (e % 100) == 0});
        end
        fast = 1'b0;
    endtask

    task automatic scen_clear();
        do_reset(1'b1, 1'b0, 1'b0);
        repeat (9) step();
        clear = 1'b1;
        step();  // edge 10 would have been a strobe
        check_eq("c_t100",  {31'd0, tick_100hz}, 32'd0);
        check_eq("c_clk",   {31'd0, clk_100hz},  32'd0);
        check_eq("c_blink", {31'd0, blink},      32'd1);
        clear = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_eq($sformatf("c_t100@%0d", i), {31'd0, tick_100hz}, {31'd0, i == 10});
            check_eq($sformatf("c_clk@%0d", i),  {31'd0, clk_100hz},  {31'd0, (i >= 5) && (i < 10)});
        end
    endtask

    task automatic scen_long();
        int c100, c10, c1;
        logic p100, p10, p1;
        c100 = 0; c10 = 0; c1 = 0;
        p100 = 1'b0; p10 = 1'b0; p1 = 1'b0;
        do_reset(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 10000; i++) begin
            step();
            if (tick_100hz) c100++;
            if (tick_10hz)  c10++;
            if (tick_1hz)   c1++;
            check_eq($sformatf("l_coinc@%0d", i),
                     {31'd0, (tick_1hz & ~tick_10hz) | (tick_10hz & ~tick_100hz)}, 32'd0);
            check_eq($sformatf("l_back2back@%0d", i),
                     {31'd0, (p100 & tick_100hz) | (p10 & tick_10hz) | (p1 & tick_1hz)}, 32'd0);
            p100 = tick_100hz; p10 = tick_10hz; p1 = tick_1hz;
        end
        check_eq("l_cnt100", 32'(c100), 32'd1000);
        check_eq("l_cnt10",  32'(c10),  32'd100);
        check_eq("l_cnt1",   32'(c1),   32'd10);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst = 1'b1; run = 1'b0; clear = 1'b0; fast = 1'b0;
        scen_normal();
        scen_pause();
        scen_fast();
        scen_clear();
        scen_long();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
